// File: rtl/subset_coord_stream.sv
// subset_coord_stream: walks an N x N pixel subset around a centre point in
// row-major order. Each beat carries float32 x/y, the linear pixel address and
// an in-image flag over a valid/ready handshake.
module subset_coord_stream #(
    parameter int COORD_W    = 16,
    parameter int MAX_SUBSET = 31,
    parameter int ADDR_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               param_ready,
    input  logic [COORD_W-1:0] subset_centerpoint_x,
    input  logic [COORD_W-1:0] subset_centerpoint_y,
    input  logic [COORD_W-1:0] subset_size,
    input  logic [COORD_W-1:0] image_width,
    input  logic [COORD_W-1:0] image_height,
    input  logic               coord_ready,
    output logic               coord_valid,
    output logic [31:0]        coord_x,
    output logic [31:0]        coord_y,
    output logic [ADDR_W-1:0]  pixel_addr,
    output logic               in_bounds,
    output logic               coord_last,
    output logic               sub_done,
    output logic               param_error
);

    // Beat coordinates get one extra bit beyond the corner width so that
    // centre + half cannot wrap at the top of the input range.
    localparam int VW = COORD_W + 2;
    localparam int PW = 2 * VW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_GEN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [COORD_W-1:0]         r_cx, r_cy, r_n, r_w, r_h;
    logic signed [COORD_W:0]    r_x0, r_y0;
    logic [COORD_W-1:0]         r_col, r_row;
    logic                       r_issued_all;
    logic                       r_valid, r_last, r_in, r_done, r_err;
    logic [31:0]                r_fx, r_fy;
    logic [ADDR_W-1:0]          r_addr;

    logic [COORD_W-1:0]         w_half, w_n_m1;
    logic                       w_bad;
    logic signed [VW-1:0]       w_x, w_y;
    logic                       w_in;
    logic [PW-1:0]              w_prod;
    logic                       w_is_last;
    logic                       w_load;
    logic                       w_accept_last;

    // Exact integer-to-float32: sign-magnitude, leading-one position gives the
    // exponent, bits below the leading one are left-aligned into the mantissa.
    function automatic logic [31:0] int_to_f32(input logic signed [VW-1:0] v);
        logic [VW-1:0] mag;
        logic [63:0]   aligned;
        int            msb;
        mag = v[VW-1] ? $unsigned(-v) : $unsigned(v);
        msb = 0;
        for (int i = 0; i < VW; i++) begin
            if (mag[i]) begin
                msb = i;
            end else begin
                msb = msb;
            end
        end
        aligned = 64'(mag) << (63 - msb);
        if (mag == {VW{1'b0}}) begin
            return 32'h0000_0000;
        end else begin
            return {v[VW-1], 8'(127 + msb), aligned[62:40]};
        end
    endfunction

    assign w_n_m1 = r_n - COORD_W'(1);
    assign w_half = w_n_m1 >> 1;
    assign w_bad  = (r_n[0] == 1'b0) || (r_n > COORD_W'(MAX_SUBSET));

    assign w_x = $signed({r_x0[COORD_W], r_x0}) + $signed({2'b00, r_col});
    assign w_y = $signed({r_y0[COORD_W], r_y0}) + $signed({2'b00, r_row});
    assign w_in = !w_x[VW-1] && !w_y[VW-1] &&
                  (w_x < $signed({2'b00, r_w})) && (w_y < $signed({2'b00, r_h}));
    assign w_prod = PW'($unsigned(w_y)) * PW'(r_w) + PW'($unsigned(w_x));
    assign w_is_last = (r_col == w_n_m1) && (r_row == w_n_m1);

    // A new beat enters the output register when it is empty or being drained.
    assign w_load = (r_state == S_GEN) && !r_issued_all && (!r_valid || coord_ready);
    assign w_accept_last = r_valid && coord_ready && r_last;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (param_ready) w_next = S_CHECK;
                else             w_next = S_IDLE;
            end
            S_CHECK: begin
                if (w_bad) w_next = S_DONE;
                else       w_next = S_GEN;
            end
            S_GEN: begin
                if (w_accept_last) w_next = S_DONE;
                else               w_next = S_GEN;
            end
            S_DONE: begin
                if (!param_ready) w_next = S_IDLE;
                else              w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Parameter latch, subset walk counters and registered beat outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cx         <= {COORD_W{1'b0}};
            r_cy         <= {COORD_W{1'b0}};
            r_n          <= {COORD_W{1'b0}};
            r_w          <= {COORD_W{1'b0}};
            r_h          <= {COORD_W{1'b0}};
            r_x0         <= {(COORD_W+1){1'b0}};
            r_y0         <= {(COORD_W+1){1'b0}};
            r_col        <= {COORD_W{1'b0}};
            r_row        <= {COORD_W{1'b0}};
            r_issued_all <= 1'b0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_in         <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_fx         <= 32'h0000_0000;
            r_fy         <= 32'h0000_0000;
            r_addr       <= {ADDR_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (param_ready) begin
                        r_cx <= subset_centerpoint_x;
                        r_cy <= subset_centerpoint_y;
                        r_n  <= subset_size;
                        r_w  <= image_width;
                        r_h  <= image_height;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_x0         <= $signed({1'b0, r_cx}) - $signed({1'b0, w_half});
                        r_y0         <= $signed({1'b0, r_cy}) - $signed({1'b0, w_half});
                        r_col        <= {COORD_W{1'b0}};
                        r_row        <= {COORD_W{1'b0}};
                        r_issued_all <= 1'b0;
                    end
                end
                S_GEN: begin
                    if (w_load) begin
                        r_valid <= 1'b1;
                        r_fx    <= int_to_f32(w_x);
                        r_fy    <= int_to_f32(w_y);
                        r_in    <= w_in;
                        r_addr  <= w_in ? ADDR_W'(w_prod) : {ADDR_W{1'b0}};
                        r_last  <= w_is_last;
                        if (w_is_last) begin
                            r_issued_all <= 1'b1;
                        end else if (r_col == w_n_m1) begin
                            r_col <= {COORD_W{1'b0}};
                            r_row <= r_row + COORD_W'(1);
                        end else begin
                            r_col <= r_col + COORD_W'(1);
                        end
                    end else if (w_accept_last) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!param_ready) begin
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign coord_valid = r_valid;
    assign coord_x     = r_fx;
    assign coord_y     = r_fy;
    assign pixel_addr  = r_addr;
    assign in_bounds   = r_in;
    assign coord_last  = r_last;
    assign sub_done    = r_done;
    assign param_error = r_err;

endmodule

// File: tb/tb_subset_coord_stream.sv
// Randomised self-checking bench for subset_coord_stream against a queue-based
// reference model of the subset walk.
module tb_subset_coord_stream;

    logic        clock = 1'b0;
    logic        reset;
    logic        param_ready;
    logic [15:0] subset_centerpoint_x, subset_centerpoint_y, subset_size;
    logic [15:0] image_width, image_height;
    logic        coord_ready;
    logic        coord_valid;
    logic [31:0] coord_x, coord_y, pixel_addr;
    logic        in_bounds, coord_last, sub_done, param_error;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] x, y, a;
        logic        ib, last;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] first_x, first_y, first_a, last_x, last_y, last_a;
    logic        first_ib;

    always #5 clock = ~clock;

    subset_coord_stream dut (
        .clock(clock), .reset(reset), .param_ready(param_ready),
        .subset_centerpoint_x(subset_centerpoint_x),
        .subset_centerpoint_y(subset_centerpoint_y),
        .subset_size(subset_size), .image_width(image_width),
        .image_height(image_height), .coord_ready(coord_ready),
        .coord_valid(coord_valid), .coord_x(coord_x), .coord_y(coord_y),
        .pixel_addr(pixel_addr), .in_bounds(in_bounds), .coord_last(coord_last),
        .sub_done(sub_done), .param_error(param_error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference float32 of an integer, derived from the double encoding.
    function automatic logic [31:0] f32(input int v);
        logic [63:0] d;
        if (v == 0) return 32'h0000_0000;
        d = $realtobits(real'(v));
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    task automatic build(input int cx, input int cy, input int n, input int w, input int h);
        int    half, x, y;
        beat_t b;
        exp_q.delete();
        half = (n - 1) / 2;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                x = cx - half + c;
                y = cy - half + r;
                b.x    = f32(x);
                b.y    = f32(y);
                b.ib   = (x >= 0) && (x < w) && (y >= 0) && (y < h);
                b.a    = b.ib ? 32'(longint'(y) * longint'(w) + longint'(x)) : 32'd0;
                b.last = (r == n - 1) && (c == n - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // mode 0: ready high, 1: alternating ready + 5-cycle stall on beat 4,
    // 2: random ready and random param_ready wiggle during generation.
    task automatic do_run(input int cx, input int cy, input int n, input int w, input int h,
                          input int mode, input bit keep);
        int          beats, cyc, stall;
        bit          stalled, prev_hold, done, rdy;
        logic [31:0] hx, hy, ha;
        beat_t       b;
        build(cx, cy, n, w, h);
        subset_centerpoint_x = 16'(cx);
        subset_centerpoint_y = 16'(cy);
        subset_size  = 16'(n);
        image_width  = 16'(w);
        image_height = 16'(h);
        coord_ready  = 1'b0;
        param_ready  = 1'b1;
        tick();
        chk("start_valid", 64'(coord_valid), 64'd0);
        // Inputs must be ignored once latched.
        subset_centerpoint_x = 16'($urandom);
        subset_centerpoint_y = 16'($urandom);
        subset_size  = 16'($urandom);
        image_width  = 16'($urandom);
        image_height = 16'($urandom);
        beats = 0; cyc = 0; stall = 0; stalled = 1'b0; prev_hold = 1'b0; done = 1'b0;
        hx = 32'd0; hy = 32'd0; ha = 32'd0;
        while (!done && cyc < 5000) begin
            if (mode == 2 && cyc >= 2) param_ready = 1'($urandom_range(0, 1));
            if (cyc == 2) chk("first_beat_latency", 64'(coord_valid), 64'd1);
            if (prev_hold) begin
                chk("hold_valid", 64'(coord_valid), 64'd1);
                chk("hold_x", 64'(coord_x), 64'(hx));
                chk("hold_y", 64'(coord_y), 64'(hy));
                chk("hold_addr", 64'(pixel_addr), 64'(ha));
            end
            if (mode == 0) begin
                rdy = 1'b1;
            end else if (mode == 1) begin
                if (coord_valid && beats == 4 && !stalled) begin
                    stalled = 1'b1;
                    stall = 5;
                end
                if (stall > 0) begin
                    rdy = 1'b0;
                    stall--;
                end else begin
                    rdy = (cyc % 2 == 0);
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            coord_ready = rdy;
            if (coord_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                    done = 1'b1;
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_x", 64'(coord_x), 64'(b.x));
                    chk("beat_y", 64'(coord_y), 64'(b.y));
                    chk("beat_addr", 64'(pixel_addr), 64'(b.a));
                    chk("beat_inb", 64'(in_bounds), 64'(b.ib));
                    chk("beat_last", 64'(coord_last), 64'(b.last));
                    if (beats == 0) begin
                        first_x = coord_x; first_y = coord_y;
                        first_a = pixel_addr; first_ib = in_bounds;
                    end
                    if (b.last) begin
                        last_x = coord_x; last_y = coord_y; last_a = pixel_addr;
                        done = 1'b1;
                    end
                end
                beats++;
            end
            prev_hold = coord_valid && !rdy;
            hx = coord_x; hy = coord_y; ha = pixel_addr;
            tick();
            cyc++;
        end
        if (!done) chk("run_timeout", 64'd0, 64'd1);
        if (mode == 0) chk("run_cycles", 64'(cyc), 64'(n * n + 2));
        chk("beat_count", 64'(beats), 64'(n * n));
        chk("done_valid_low", 64'(coord_valid), 64'd0);
        chk("sub_done_set", 64'(sub_done), 64'd1);
        chk("no_param_error", 64'(param_error), 64'd0);
        coord_ready = 1'b0;
        if (keep) begin
            param_ready = 1'b1;
            repeat (3) tick();
            chk("done_hold", 64'(sub_done), 64'd1);
            chk("done_hold_valid", 64'(coord_valid), 64'd0);
        end
        param_ready = 1'b0;
        tick();
        chk("sub_done_clear", 64'(sub_done), 64'd0);
    endtask

    task automatic do_err(input int n);
        subset_centerpoint_x = 16'd10;
        subset_centerpoint_y = 16'd20;
        subset_size  = 16'(n);
        image_width  = 16'd640;
        image_height = 16'd480;
        coord_ready  = 1'b1;
        param_ready  = 1'b1;
        tick();
        chk("err_valid_t0", 64'(coord_valid), 64'd0);
        tick();
        chk("err_valid_t1", 64'(coord_valid), 64'd0);
        tick();
        chk("err_flag", 64'(param_error), 64'd1);
        chk("err_done", 64'(sub_done), 64'd1);
        chk("err_valid_t2", 64'(coord_valid), 64'd0);
        param_ready = 1'b0;
        tick();
        chk("err_flag_clear", 64'(param_error), 64'd0);
        chk("err_done_clear", 64'(sub_done), 64'd0);
        coord_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(coord_valid), 64'd0);
        chk({tag, "_x"}, 64'(coord_x), 64'd0);
        chk({tag, "_y"}, 64'(coord_y), 64'd0);
        chk({tag, "_addr"}, 64'(pixel_addr), 64'd0);
        chk({tag, "_flags"}, 64'({in_bounds, coord_last, sub_done, param_error}), 64'd0);
    endtask

    initial begin
        reset = 1'b1; param_ready = 1'b0; coord_ready = 1'b0;
        subset_centerpoint_x = 16'd0; subset_centerpoint_y = 16'd0; subset_size = 16'd0;
        image_width = 16'd0; image_height = 16'd0;
        repeat (2) tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Basic 3x3 and spec spot values.
        do_run(10, 20, 3, 640, 480, 0, 1'b0);
        chk("basic_b0_x", 64'(first_x), 64'h4110_0000);
        chk("basic_b0_y", 64'(first_y), 64'h4198_0000);
        chk("basic_b0_addr", 64'(first_a), 64'd12169);
        chk("basic_b0_inb", 64'(first_ib), 64'd1);
        chk("basic_b8_x", 64'(last_x), 64'h4130_0000);
        chk("basic_b8_y", 64'(last_y), 64'h41A8_0000);
        chk("basic_b8_addr", 64'(last_a), 64'd13451);

        // Backpressure.
        do_run(10, 20, 3, 640, 480, 1, 1'b0);

        // Image edge.
        do_run(0, 0, 3, 640, 480, 0, 1'b0);
        chk("edge_b0_x", 64'(first_x), 64'hBF80_0000);
        chk("edge_b0_y", 64'(first_y), 64'hBF80_0000);
        chk("edge_b0_inb", 64'(first_ib), 64'd0);
        chk("edge_b0_addr", 64'(first_a), 64'd0);
        chk("edge_b8_addr", 64'(last_a), 64'd641);

        // Illegal sizes.
        do_err(4);
        do_err(0);
        do_err(33);

        // Reset mid-run after 100 accepted beats.
        subset_centerpoint_x = 16'd100; subset_centerpoint_y = 16'd200;
        subset_size = 16'd31; image_width = 16'd640; image_height = 16'd480;
        coord_ready = 1'b1;
        param_ready = 1'b1;
        tick();
        param_ready = 1'b0;
        repeat (102) tick();
        chk("midrun_valid", 64'(coord_valid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("midrun_reset");
        repeat (3) tick();
        chk("post_reset_idle", 64'(coord_valid), 64'd0);
        coord_ready = 1'b0;
        do_run(100, 200, 31, 640, 480, 0, 1'b0);
        chk("n31_last_x", 64'(last_x), 64'(f32(115)));
        chk("n31_last_y", 64'(last_y), 64'(f32(215)));

        // N=1 with DONE hold, then identical re-run.
        do_run(37, 5, 1, 640, 480, 0, 1'b1);
        chk("n1_x", 64'(first_x), 64'(f32(37)));
        chk("n1_y", 64'(first_y), 64'(f32(5)));
        do_run(37, 5, 1, 640, 480, 0, 1'b0);
        chk("n1_rerun_addr", 64'(first_a), 64'd3237);

        // Random runs.
        for (int k = 0; k < 20; k++) begin
            do_run(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                   2 * int'($urandom_range(0, 4)) + 1,
                   int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/subset_coord_stream.md
# subset_coord_stream

Parametrised, streaming successor to the fixed 3x3 subset coordinate generator. It sits between the parameters IP and the gamma IP and takes a subset centre, a runtime subset size and the image dimensions. It emits every pixel coordinate of the square subset in row-major order, one per accepted handshake, as IEEE-754 single-precision x/y. Each coordinate also carries its linear pixel address and an in-image flag. A flat output bus is no longer used, so subset size is limited only by `MAX_SUBSET`.

## Interface

Parameters:
- `COORD_W`, 16: width of centre, size and image-dimension inputs. Must be ≤ 23 so conversion is exact.
- `MAX_SUBSET`, 31: largest legal subset size; must be odd.
- `ADDR_W`, 32: width of `pixel_addr`.

Ports:
- `clock` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `param_ready` input 1: start request; level, sampled in IDLE.
- `subset_centerpoint_x` input COORD_W: unsigned centre x.
- `subset_centerpoint_y` input COORD_W: unsigned centre y.
- `subset_size` input COORD_W: side length N; odd, 1..MAX_SUBSET.
- `image_width` input COORD_W: image width W in pixels.
- `image_height` input COORD_W: image height H in pixels.
- `coord_ready` input 1: downstream accept.
- `coord_valid` output 1: coordinate beat valid.
- `coord_x` output 32: x as float32.
- `coord_y` output 32: y as float32.
- `pixel_addr` output ADDR_W: y*W+x when in bounds, else 0.
- `in_bounds` output 1: 0≤x<W and 0≤y<H.
- `coord_last` output 1: final beat of the subset.
- `sub_done` output 1: run complete (normal or error).
- `param_error` output 1: illegal `subset_size`.

## Operation

- Inputs are latched on the IDLE→CHECK transition and ignored until the next run.
- half = (N-1)/2. x0 = cx-half and y0 = cy-half, held as signed COORD_W+1.
- Beat order: row-major. col runs 0..N-1 fastest, then row runs 0..N-1.
- Beat values: x = x0+col, y = y0+row. Total beats are N*N.
- Float conversion is integer to float32: sign-magnitude, leading-one detect, exponent 127+msb, mantissa left-aligned with no rounding (exact).
- Integer 0 converts to 0x00000000.
- The address multiply is full width and truncated to ADDR_W.
- FSM states:
  - IDLE: go to CHECK when `param_ready`=1.
  - CHECK: if N is even, N=0 or N>MAX_SUBSET, set `param_error`=1 and go to DONE. Otherwise compute x0/y0, clear counters and go to GEN.
  - GEN: the output register loads a new beat when `coord_valid`=0 or `coord_ready`=1. On an accepted beat with `coord_last`=1, drop `coord_valid` and go to DONE.
  - DONE: `sub_done`=1. Stay in DONE while `param_ready`=1. On `param_ready`=0, clear `sub_done`/`param_error` and go to IDLE.
- Output hold: while `coord_valid`=1 and `coord_ready`=0, all coordinate outputs are frozen.
- N=1 produces a single beat with `coord_last`=1.
- Negative x or y: float sign bit set, `in_bounds`=0, `pixel_addr`=0.

## Timing

- Reset values: `coord_valid`, `coord_last`, `in_bounds`, `sub_done` and `param_error` = 0. `coord_x`, `coord_y` and `pixel_addr` = 0. State = IDLE, counters = 0.
- Reset mid-run returns to IDLE on the next edge and drops `coord_valid` with no further beats. A new run needs `param_ready` sampled again.
- Latency: `param_ready` sampled high at edge T puts the first beat valid after edge T+2.
- Throughput: one beat per cycle while `coord_ready`=1, so a full run takes N*N+2 cycles from start to the last beat.
- `sub_done` rises on the edge after the last beat is accepted. Error case: `sub_done`=`param_error`=1 at T+2, with `coord_valid` never asserted.
- `param_ready` toggling during GEN has no effect.

## Test plan

- **Basic 3x3:** centre (10,20), N=3, W=640, H=480, ready tied high.
  - Beat 0: x=0x41100000 (9), y=0x41980000 (19), addr 12169, in_bounds=1.
  - Beat 8: x=0x41300000 (11), y=0x41A80000 (21), addr 13451, `coord_last`=1.
  - `sub_done`=1 one cycle later.
- **Backpressure:** same run with `coord_ready` low on alternating cycles, plus a 5-cycle stall on beat 4. Outputs must hold stable while stalled, with exactly 9 beats and none duplicated or dropped.
- **Image edge:** centre (0,0), N=3.
  - Beat 0: x=y=0xBF800000 (-1), in_bounds=0, addr 0.
  - Beat 4: x=y=0x00000000, in_bounds=1, addr 0.
  - Beat 8: (1,1), addr W+1.
- **Illegal size:** N=4, then N=0, then N=33.
  - Each gives `param_error`=1 and `sub_done`=1 with zero beats.
  - Lowering `param_ready` clears both flags.
- **Reset mid-run:** N=31; assert `reset` after beat 100 for 1 cycle.
  - `coord_valid`=0 next cycle and all outputs return to reset values.
  - A restart produces all 961 beats, with the last at (cx+15, cy+15).
- **N=1 and re-run:** N=1 gives a single beat with `coord_last`=1 at (cx,cy). Holding `param_ready` high keeps the block in DONE; a low-then-high sequence starts a second identical run.
